// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types for the ioctl-to-SDRAM ROM loader
package loader_pkg;

    typedef logic [31:0] word_t;
    typedef logic [22:0] waddr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } loader_state_t;

    localparam int ENTRY_W = 55;

endpackage

// File: rtl/loader_fifo.sv
// rtl/loader_fifo.sv - packed-word queue between the byte packer and the SDRAM port
module loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 55,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is never reset; the top gates the head while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// rtl/ioctl_sdram_loader.sv - packs ioctl download bytes into 32-bit SDRAM writes; LOADER_CHECKSUM_EN adds a byte checksum
module ioctl_sdram_loader
    import loader_pkg::*;
#(
    parameter waddr_t BASE_WORD  = '0,
    parameter int     FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [22:0] sdram_addr,
    output logic [31:0] sdram_data,
    output logic        sdram_we,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic        busy,
    output logic        done,
    output logic        error
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    loader_state_t        state;
    logic                 dl_q;
    word_t                acc_data;
    waddr_t               acc_idx;
    logic                 acc_valid;
    word_t                nxt_data;
    waddr_t               nxt_idx;
    logic                 nxt_valid;
    logic                 dl_rise;
    logic                 dl_fall;
    logic                 wr_en;
    logic                 mismatch;
    logic                 push;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CW-1:0]        count;

    assign dl_rise  = ioctl_download && !dl_q;
    assign dl_fall  = !ioctl_download && dl_q;
    assign wr_en    = (state == ST_LOAD) && ioctl_wr;
    assign mismatch = wr_en && acc_valid && (ioctl_addr[24:2] != acc_idx);

    // Next accumulator view: the current byte is merged before any flush decision.
    always_comb begin
        nxt_data  = acc_data;
        nxt_idx   = acc_idx;
        nxt_valid = acc_valid;
        if (wr_en) begin
            if (mismatch) begin
                nxt_data = '0;
            end
            nxt_data[{ioctl_addr[1:0], 3'b000} +: 8] = ioctl_data;
            nxt_idx   = ioctl_addr[24:2];
            nxt_valid = 1'b1;
        end
    end

    assign push = (state == ST_LOAD) &&
                  ((wr_en && (ioctl_addr[1:0] == 2'd3)) || (dl_fall && nxt_valid));
    assign push_entry = {BASE_WORD + nxt_idx, nxt_data};

    // Edge history keeps sampling through reset so a window held open across reset is not a new download.
    always_ff @(posedge clk) begin
        dl_q <= ioctl_download;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            acc_data  <= '0;
            acc_idx   <= '0;
            acc_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dl_rise) begin
                        state     <= ST_LOAD;
                        error     <= 1'b0;
                        acc_data  <= '0;
                        acc_idx   <= '0;
                        acc_valid <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (push) begin
                        acc_data  <= '0;
                        acc_valid <= 1'b0;
                    end else begin
                        acc_data  <= nxt_data;
                        acc_idx   <= nxt_idx;
                        acc_valid <= nxt_valid;
                    end
                    if (mismatch || (push && fifo_full)) begin
                        error <= 1'b1;
                    end
                    if (dl_fall) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && dl_rise) begin
            checksum <= '0;
        end else if (wr_en) begin
            checksum <= checksum + {8'h00, ioctl_data};
        end
    end
`endif

    loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (sdram_ack),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

    assign sdram_req  = !fifo_empty;
    assign sdram_we   = sdram_req;
    assign sdram_addr = sdram_req ? head[54:32] : '0;
    assign sdram_data = sdram_req ? head[31:0]  : '0;
    assign ioctl_wait = (count >= CW'(FIFO_DEPTH - 1));
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_FLUSH) && fifo_empty;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// tb/tb_ioctl_sdram_loader.sv - directed self-checking bench for ioctl_sdram_loader
module tb_ioctl_sdram_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        sdram_ack;

    logic        wait0, we0, req0, busy0, done0, err0;
    logic [22:0] addr0;
    logic [31:0] data0;
    logic        wait1, we1, req1, busy1, done1, err1;
    logic [22:0] addr1;
    logic [31:0] data1;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] cs0, cs1;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ioctl_sdram_loader dut0 (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wait(wait0), .sdram_addr(addr0), .sdram_data(data0),
        .sdram_we(we0), .sdram_req(req0), .sdram_ack(sdram_ack),
        .busy(busy0), .done(done0), .error(err0)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cs0)
`endif
    );

    ioctl_sdram_loader #(.BASE_WORD(23'h100000)) dut1 (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wait(wait1), .sdram_addr(addr1), .sdram_data(data1),
        .sdram_we(we1), .sdram_req(req1), .sdram_ack(sdram_ack),
        .busy(busy1), .done(done1), .error(err1)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(cs1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        sdram_ack      = 1'b0;
        repeat (3) tick();

        chk("rst_req",   64'(req0),  64'd0);
        chk("rst_we",    64'(we0),   64'd0);
        chk("rst_addr",  64'(addr0), 64'd0);
        chk("rst_data",  64'(data0), 64'd0);
        chk("rst_wait",  64'(wait0), 64'd0);
        chk("rst_busy",  64'(busy0), 64'd0);
        chk("rst_done",  64'(done0), 64'd0);
        chk("rst_error", 64'(err0),  64'd0);

        reset_n = 1'b1;
        tick();

        // Writes in IDLE are ignored
        wr_byte(25'd3, 8'h99);
        tick();
        chk("idle_wr_req", 64'(req0), 64'd0);

        // Single full word, ack two cycles after req
        ioctl_download = 1'b1;
        tick();
        chk("w1_busy", 64'(busy0), 64'd1);
        wr_byte(25'd0, 8'h11);
        wr_byte(25'd1, 8'h22);
        wr_byte(25'd2, 8'h33);
        chk("w1_noreq", 64'(req0), 64'd0);
        wr_byte(25'd3, 8'h44);
        chk("w1_req",   64'(req0),  64'd1);
        chk("w1_we",    64'(we0),   64'd1);
        chk("w1_addr",  64'(addr0), 64'd0);
        chk("w1_data",  64'(data0), 64'h44332211);
        chk("w1_base",  64'(addr1), 64'h100000);
        ioctl_download = 1'b0;
        tick();
        chk("w1_hold_data", 64'(data0), 64'h44332211);
        chk("w1_flush_done", 64'(done0), 64'd0);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("w1_done",  64'(done0), 64'd1);
        chk("w1_req0",  64'(req0),  64'd0);
        tick();
        chk("w1_done_once", 64'(done0), 64'd0);
        chk("w1_idle",      64'(busy0), 64'd0);

        // Five bytes then falling edge flushes a zero-filled partial word
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) wr_byte(25'(i), 8'hAA);
        ioctl_download = 1'b0;
        tick();
        chk("w2_a_addr", 64'(addr0), 64'd0);
        chk("w2_a_data", 64'(data0), 64'hAAAAAAAA);
        sdram_ack = 1'b1;
        tick();
        chk("w2_b_addr", 64'(addr0), 64'd1);
        chk("w2_b_data", 64'(data0), 64'h000000AA);
        tick();
        sdram_ack = 1'b0;
        chk("w2_done", 64'(done0), 64'd1);
        tick();

        // Backpressure with offset base, then ordered drain
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) wr_byte(25'(i), 8'(i));
        chk("w3_nowait", 64'(wait1), 64'd0);
        for (int i = 8; i < 12; i++) wr_byte(25'(i), 8'(i));
        chk("w3_wait", 64'(wait1), 64'd1);
        for (int i = 12; i < 16; i++) wr_byte(25'(i), 8'(i));
        ioctl_download = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("w3_addr%0d", k), 64'(addr1), 64'(23'h100000 + k));
            chk($sformatf("w3_data%0d", k), 64'(data1),
                64'({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}));
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
        end
        chk("w3_done",  64'(done1), 64'd1);
        chk("w3_noerr", 64'(err1),  64'd0);
        tick();

        // Address jump discards pending bytes and sets error
        ioctl_download = 1'b1;
        tick();
        wr_byte(25'd0, 8'h5A);
        wr_byte(25'd1, 8'h6B);
        chk("w4_noerr", 64'(err0), 64'd0);
        wr_byte(25'd8, 8'h7C);
        chk("w4_err", 64'(err0), 64'd1);
        ioctl_download = 1'b0;
        tick();
        chk("w4_addr", 64'(addr0), 64'd2);
        chk("w4_data", 64'(data0), 64'h0000007C);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("w4_done", 64'(done0), 64'd1);
        tick();
        chk("w4_sticky", 64'(err0), 64'd1);

        // Write coinciding with the falling edge is merged before the flush
        ioctl_download = 1'b1;
        tick();
        chk("w5_err_clr", 64'(err0), 64'd0);
        wr_byte(25'd0, 8'h01);
        ioctl_download = 1'b0;
        wr_byte(25'd1, 8'h02);
        chk("w5_data", 64'(data0), 64'h00000201);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("w5_done", 64'(done0), 64'd1);
        tick();

        // Reset mid-transfer drops the request; no done afterwards
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'hC0 + 8'(i));
        chk("w6_req", 64'(req0), 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("w6_req0",  64'(req0),  64'd0);
        chk("w6_busy0", 64'(busy0), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("w6_nodone%0d", i), 64'({done0, busy0, req0}), 64'd0);
        end
        ioctl_download = 1'b0;
        tick();

`ifdef LOADER_CHECKSUM_EN
        ioctl_download = 1'b1;
        tick();
        sdram_ack = 1'b1;
        for (int i = 0; i < 256; i++) wr_byte(25'(i), 8'hFF);
        ioctl_download = 1'b0;
        repeat (3) tick();
        sdram_ack = 1'b0;
        chk("cs_sum", 64'(cs0), 64'hFF00);
        tick();
        chk("cs_hold", 64'(cs0), 64'hFF00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
